serial_in: RTL and testbench

- UART receiver (8N1, LSB first). Counterpart to the serial transmitter on the board's UART pins.
- Converts the incoming line into bytes held in a one-entry output buffer with a valid/ready handshake.
- Feeds the BF core's input-byte path; a later top-level change wires the `,` opcode to it.
- Runs on the fast base clock, not on the divided core clock.

---
 rtl/serial_in.sv | 217 +++++++++++++++++++++
 tb/tb_serial_in.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_in.sv
// ---------------------------------------------------------------------------
// serial_in : UART receiver, 8N1, LSB first, with a one-entry output buffer.
//
// Optional build macro: SERIAL_IN_PARITY_EN
//   When defined, a parity bit is expected between the data bits and the
//   stop bit. Parameter PARITY_ODD and output parity_err are added. A byte
//   with bad parity is discarded, and stop-bit handling is unchanged.
//
// Parameters:
//   CLK_FREQ  base clock frequency in Hz
//   BAUD      line rate in bit/s (CLK_FREQ/BAUD must be >= 4)
//
// Ports:
//   clk        base clock (fast clock, not the divided core clock)
//   rst        asynchronous active-high reset, clears all state
//   uart_rx    serial line, idle high, asynchronous to clk
//   char       received byte, stable while valid=1
//   valid      char holds an unconsumed byte
//   ready      consumer takes char on a cycle with valid&ready=1
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: new byte dropped, buffer was full
//   parity_err one-cycle pulse at the stop sample on parity mismatch
//              (only with SERIAL_IN_PARITY_EN)
// ---------------------------------------------------------------------------
module serial_in #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
`ifdef SERIAL_IN_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] char,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
`ifdef SERIAL_IN_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_IN_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       shift, shift_n;
    logic             rx_m, rx_s;

    logic             stop_hit;
    logic             deliver;
    logic             consume;
    logic [7:0]       char_n;
    logic             valid_n;
    logic             frame_err_n;
    logic             overrun_n;

`ifdef SERIAL_IN_PARITY_EN
    logic             par_bad, par_bad_n;
    logic             parity_err_n;
`endif

    // Input synchronizer: both flops idle high so reset never fakes a start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
        end
    end

    // Next-state logic. The baud counter restarts at 0 on every state entry,
    // so the START check lands mid start bit and each later sample lands one
    // full bit period after the previous one, i.e. mid-bit.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        idx_n    = idx;
        shift_n  = shift;
        stop_hit = 1'b0;
`ifdef SERIAL_IN_PARITY_EN
        par_bad_n = par_bad;
`endif
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    idx_n   = 3'd0;
                    state_n = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n        = '0;
                    shift_n[idx] = rx_s;
                    if (idx == 3'd7) begin
`ifdef SERIAL_IN_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
`ifdef SERIAL_IN_PARITY_EN
            S_PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_n     = '0;
                    par_bad_n = ((^shift) ^ rx_s) != PARITY_ODD;
                    state_n   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n    = '0;
                    stop_hit = 1'b1;
                    state_n  = rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                // A line held low must go high before a new start is seen.
                cnt_n = '0;
                if (rx_s) state_n = S_IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // Output buffer and pulses. Only the stop sample can deliver, so
    // frame_err and overrun are mutually exclusive by construction.
    always_comb begin
`ifdef SERIAL_IN_PARITY_EN
        deliver      = stop_hit & rx_s & ~par_bad;
        parity_err_n = stop_hit & par_bad;
`else
        deliver      = stop_hit & rx_s;
`endif
        frame_err_n = stop_hit & ~rx_s;
        consume     = valid & ready;
        char_n      = char;
        valid_n     = valid & ~consume;
        overrun_n   = 1'b0;
        if (deliver) begin
            if (!valid || ready) begin
                char_n  = shift;
                valid_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
            end
        end
    end

    // Register stage: FSM state, datapath and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= 3'd0;
            shift     <= 8'h00;
            char      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SERIAL_IN_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shift     <= shift_n;
            char      <= char_n;
            valid     <= valid_n;
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
`ifdef SERIAL_IN_PARITY_EN
            par_bad    <= par_bad_n;
            parity_err <= parity_err_n;
`endif
        end
    end

endmodule

// File: tb/tb_serial_in.sv
// ---------------------------------------------------------------------------
// tb_serial_in : self-checking bench for serial_in at 16 clocks per bit.
// A frame-timing reference model predicts valid/char/frame_err/overrun on
// every cycle; directed scenarios add literal expectations, then a random
// phase mixes random bytes, bad stop bits, glitches and random ready.
// ---------------------------------------------------------------------------
module tb_serial_in;

    localparam int C = 16;      // clocks per bit
    localparam int H = C / 2;   // half bit

    logic       clk;
    logic       rst;
    logic       uart_rx;
    logic [7:0] char;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
`ifdef SERIAL_IN_PARITY_EN
    logic       parity_err;
`endif

    serial_in #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .char      (char),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
`ifdef SERIAL_IN_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // s is the line value the receiver sees at an edge: the line two edges
    // earlier (two-flop synchronizer, idle high after reset). A frame that
    // begins at edge t0 is checked at t0+H, data bit k sampled at
    // t0+H+C*(k+1), stop at t0+H+9C.
    int         cyc;
    logic       l1, l2, s;
    bit         busy, brk;
    int         t0, d;
    logic [7:0] m_data;
    logic [7:0] m_char;
    bit         m_valid, m_fe, m_ov, m_deliver, m_cons;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            l1 = 1'b1; l2 = 1'b1;
            busy = 0; brk = 0; m_data = 8'h00;
            m_char = 8'h00; m_valid = 0; m_fe = 0; m_ov = 0;
        end else begin
            s  = l2;
            l2 = l1;
            l1 = uart_rx;
            m_cons    = m_valid && ready;
            m_fe      = 0;
            m_ov      = 0;
            m_deliver = 0;
            if (brk) begin
                if (s) brk = 0;
            end else if (!busy) begin
                if (!s) begin
                    busy = 1;
                    t0   = cyc;
                end
            end else begin
                d = cyc - t0;
                if (d == H) begin
                    if (s) busy = 0;
                end else if (d == H + 9 * C) begin
                    busy = 0;
                    if (s) m_deliver = 1;
                    else begin
                        m_fe = 1;
                        brk  = 1;
                    end
                end else if (d > H && (d - H) % C == 0) begin
                    m_data[(d - H) / C - 1] = s;
                end
            end
            if (m_deliver) begin
                if (!m_valid || ready) begin
                    m_char  = m_data;
                    m_valid = 1;
                end else begin
                    m_ov = 1;
                end
            end else if (m_cons) begin
                m_valid = 0;
            end
        end
    end

    // ---------------- stimulus, checking and statistics ----------------
    int         checks, passes;
    int         vcnt, fecnt, ovcnt, rise_cyc;
    logic [7:0] rise_char;
    bit         pv, rand_ready;
    int         start_cyc;
    int         b_v, b_fe, b_ov;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_range(string name, int act, int lo, int hi);
        checks++;
        if (act >= lo && act <= hi) passes++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    // One clock: compare just after the edge, then drive at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        checks++;
        if ({valid, char, frame_err, overrun} === {m_valid, m_char, m_fe, m_ov})
            passes++;
        else
            $display("FAIL cycle %0d: dut valid=%0b char=%02h fe=%0b ov=%0b, model valid=%0b char=%02h fe=%0b ov=%0b",
                     cyc, valid, char, frame_err, overrun, m_valid, m_char, m_fe, m_ov);
        if (valid && !pv) begin
            rise_cyc  = cyc;
            rise_char = char;
        end
        if (valid === 1'b1) vcnt++;
        if (frame_err === 1'b1) fecnt++;
        if (overrun === 1'b1) ovcnt++;
        pv = (valid === 1'b1);
        @(negedge clk);
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    endtask

    task automatic line(logic v, int n);
        uart_rx = v;
        repeat (n) tick();
    endtask

    task automatic send(logic [7:0] b, logic stop_bit, int nbits);
        start_cyc = cyc;
        line(1'b0, C);
        for (int i = 0; i < nbits; i++) line(b[i], C);
        if (nbits == 8) line(stop_bit, C);
    endtask

    task automatic mark();
        b_v = vcnt; b_fe = fecnt; b_ov = ovcnt;
    endtask

    initial begin
        cyc = 0; checks = 0; passes = 0;
        vcnt = 0; fecnt = 0; ovcnt = 0; rise_cyc = 0; rise_char = 8'h00; pv = 0;
        rand_ready = 0;
        uart_rx = 1'b1; ready = 1'b1; rst = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_valid", valid, 0);
        check("rst_char", char, 8'h00);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        line(1'b1, 10);

        // 0x41 with ready=1: one-cycle valid
        mark();
        send(8'h41, 1'b1, 8);
        line(1'b1, 10);
        check("t1_valid_cycles", vcnt - b_v, 1);
        check("t1_char", rise_char, 8'h41);
        check("t1_model_char", m_char, 8'h41);
        check("t1_frame_err", fecnt - b_fe, 0);
        check("t1_overrun", ovcnt - b_ov, 0);

        // 0xA5 with ready=0: latency, hold, consume
        ready = 1'b0;
        send(8'hA5, 1'b1, 8);
        check_range("t2_latency", rise_cyc - start_cyc, 2 + H + 9 * C - 1, 2 + H + 9 * C + 1);
        check("t2_valid_held", valid, 1);
        check("t2_char", char, 8'hA5);
        ready = 1'b1;
        tick();
        check("t2_valid_drop", valid, 0);
        line(1'b1, 5);

        // Overrun: 0x11 then 0x22 with ready=0
        ready = 1'b0;
        mark();
        send(8'h11, 1'b1, 8);
        line(1'b1, 4);
        send(8'h22, 1'b1, 8);
        line(1'b1, 4);
        check("t3_char_kept", char, 8'h11);
        check("t3_valid", valid, 1);
        check("t3_overrun_pulses", ovcnt - b_ov, 1);
        ready = 1'b1;
        line(1'b1, 3);

        // Glitch of 5 cycles, then 0x3C
        mark();
        line(1'b0, 5);
        line(1'b1, 30);
        check("t4_glitch_valid", vcnt - b_v, 0);
        check("t4_glitch_fe", fecnt - b_fe, 0);
        send(8'h3C, 1'b1, 8);
        line(1'b1, 10);
        check("t4_char", rise_char, 8'h3C);
        check("t4_valid_cycles", vcnt - b_v, 1);

        // Framing error on 0x55 with long break, then 0x0F
        mark();
        send(8'h55, 1'b0, 8);
        line(1'b0, 40);
        line(1'b1, 20);
        check("t5_frame_err", fecnt - b_fe, 1);
        check("t5_no_valid", vcnt - b_v, 0);
        send(8'h0F, 1'b1, 8);
        line(1'b1, 10);
        check("t5_char", rise_char, 8'h0F);
        check("t5_valid_cycles", vcnt - b_v, 1);
        check("t5_fe_total", fecnt - b_fe, 1);

        // Reset mid-frame of 0xFF, then 0x80
        mark();
        send(8'hFF, 1'b1, 4);
        rst = 1'b1;
        repeat (3) tick();
        check("t6_rst_valid", valid, 0);
        check("t6_rst_char", char, 8'h00);
        check("t6_rst_fe", frame_err, 0);
        rst = 1'b0;
        line(1'b1, 20);
        send(8'h80, 1'b1, 8);
        line(1'b1, 10);
        check("t6_valid_cycles", vcnt - b_v, 1);
        check("t6_char", rise_char, 8'h80);
        check("t6_fe", fecnt - b_fe, 0);

        // Random phase
        rand_ready = 1;
        for (int n = 0; n < 25; n++) begin
            logic [7:0] b;
            logic       stp;
            b   = 8'($urandom);
            stp = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 4) == 0) begin
                line(1'b0, $urandom_range(1, 6));
                line(1'b1, $urandom_range(3, 10));
            end
            send(b, stp, 8);
            if (!stp) line(1'b0, $urandom_range(0, 30));
            line(1'b1, $urandom_range(1, 20));
        end
        rand_ready = 0;
        ready = 1'b1;
        line(1'b1, 5);
        check("end_drained", valid, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
